// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor / BTB: counter states and the table entry layout.
package branch_predictor_pkg;

  // Widest tag a 32-bit word-aligned PC can need (ENTRIES >= 2 leaves at most 29 bits).
  localparam int BP_TAG_MAX_W = 30;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_INIT = CTR_WNT;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:0]             target;
    bp_ctr_t                 ctr;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and MEM-side training signals between the pipeline and the predictor.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_npc;
  logic        mispredict;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
    input  pred_taken, pred_npc, mispredict
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
    output pred_taken, pred_npc, mispredict
  );
endinterface

// File: rtl/bp_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        inc,
  output logic [31:0] cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup in IF,
// training from resolved conditional branches in MEM, plus saturating statistics.
import branch_predictor_pkg::*;

module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  branch_predictor_if.slave  bp,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Tags are stored zero-extended into the fixed-width package field.
  function automatic logic [BP_TAG_MAX_W-1:0] make_tag(input logic [31:0] pc);
    logic [TAG_W-1:0] t;
    t = pc[31:IDX_W+2];
    return {{(BP_TAG_MAX_W-TAG_W){1'b0}}, t};
  endfunction

  function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
    bp_ctr_t r;
    case (c)
      CTR_SNT: r = CTR_WNT;
      CTR_WNT: r = CTR_WT;
      default: r = CTR_ST;
    endcase
    return r;
  endfunction

  function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
    bp_ctr_t r;
    case (c)
      CTR_ST:  r = CTR_WT;
      CTR_WT:  r = CTR_WNT;
      default: r = CTR_SNT;
    endcase
    return r;
  endfunction

  bp_entry_t        tbl [ENTRIES];
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  bp_entry_t        lk_e;
  bp_entry_t        up_e;
  logic             lk_hit;
  logic             up_hit;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign lk_idx = bp.if_pc[IDX_W+1:2];
  assign lk_e   = tbl[lk_idx];
  assign lk_hit = lk_e.valid && (lk_e.tag == make_tag(bp.if_pc));

  assign bp.pred_taken = lk_hit & lk_e.ctr[1];
  assign bp.pred_npc   = bp.pred_taken ? lk_e.target : bp.if_pc + 32'd4;

  assign up_idx = bp.upd_pc[IDX_W+1:2];
  assign up_e   = tbl[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == make_tag(bp.upd_pc));

  assign bp.mispredict = (bp.upd_pred_taken != bp.upd_taken) ||
                         (bp.upd_pred_taken && bp.upd_taken && (bp.upd_pred_npc != bp.upd_target));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_INIT};
      end
    end else if (bp.upd_valid) begin
      if (up_hit) begin
        if (bp.upd_taken) begin
          tbl[up_idx].ctr    <= ctr_inc(up_e.ctr);
          tbl[up_idx].target <= bp.upd_target;
        end else begin
          tbl[up_idx].ctr    <= ctr_dec(up_e.ctr);
        end
      end else if (bp.upd_taken) begin
        // Not-taken misses never allocate; taken misses evict whatever aliased here.
        tbl[up_idx] <= '{valid: 1'b1, tag: make_tag(bp.upd_pc), target: bp.upd_target, ctr: CTR_WT};
      end
    end
  end

  bp_sat_counter u_stat_branches (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (bp.upd_valid),
    .cnt  (stat_branches)
  );

  bp_sat_counter u_stat_mispredicts (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (bp.upd_valid & bp.mispredict),
    .cnt  (stat_mispredicts)
  );

endmodule
